// File: rtl/adsr_if.sv
// Key-event, envelope-parameter and envelope-output bundle between the keyboard FSM / switch
// registers and the ADSR envelope generator.
interface adsr_if;
  logic        start;
  logic        gate_off;
  logic [31:0] atk_step;
  logic [31:0] dcy_step;
  logic [31:0] sus_level;
  logic [31:0] sus_time;
  logic [31:0] rel_step;
  logic [15:0] env;
  logic        adsr_idle;

  modport master (
    output start, gate_off, atk_step, dcy_step, sus_level, sus_time, rel_step,
    input  env, adsr_idle
  );

  modport slave (
    input  start, gate_off, atk_step, dcy_step, sus_level, sus_time, rel_step,
    output env, adsr_idle
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope for the DDFS stage: one envelope step per clock, Q2.14 output
// (16'h4000 = unity), with a bypass code that pins the output at full scale.
module adsr_envelope #(
  parameter logic [31:0] MAX_LEVEL   = 32'h8000_0000,
  parameter logic [31:0] BYPASS_CODE = 32'hFFFF_FFFF
) (
  input  logic   CLK100MHZ,
  input  logic   reset,
  adsr_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4,
    BYPASS  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sus_cnt_q, sus_cnt_d;
  logic [31:0] atk_s, dcy_s, sus_s, sus_time_s, rel_s;
  logic [31:0] sus_clamped_c;

  assign sus_clamped_c = (bus.sus_level > MAX_LEVEL) ? MAX_LEVEL : bus.sus_level;

  // State, accumulator, note-parameter shadows and registered outputs
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      sus_cnt_q     <= '0;
      atk_s         <= '0;
      dcy_s         <= '0;
      sus_s         <= '0;
      sus_time_s    <= '0;
      rel_s         <= '0;
      bus.env       <= '0;
      bus.adsr_idle <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sus_cnt_q <= sus_cnt_d;
      if (bus.start) begin
        atk_s      <= bus.atk_step;
        dcy_s      <= bus.dcy_step;
        sus_s      <= sus_clamped_c;
        sus_time_s <= bus.sus_time;
        rel_s      <= bus.rel_step;
      end
      bus.env       <= {1'b0, acc_q[31:17]};
      bus.adsr_idle <= (state_q == IDLE);
    end
  end

  // Next state / accumulator; all limits compared as remaining headroom so nothing wraps
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sus_cnt_d = sus_cnt_q;

    if (bus.start) begin
      // Retrigger keeps the current level so the restart is click-free
      state_d   = (bus.atk_step == BYPASS_CODE) ? BYPASS : ATTACK;
      sus_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        ATTACK: begin
          if (bus.gate_off) begin
            state_d = RELEASE;
          end else if (atk_s >= MAX_LEVEL - acc_q) begin
            acc_d   = MAX_LEVEL;
            state_d = DECAY;
          end else begin
            acc_d = acc_q + atk_s;
          end
        end
        DECAY: begin
          if (bus.gate_off) begin
            state_d = RELEASE;
          end else if ((acc_q <= sus_s) || ((acc_q - sus_s) <= dcy_s)) begin
            acc_d   = sus_s;
            state_d = SUSTAIN;
          end else begin
            acc_d = acc_q - dcy_s;
          end
        end
        SUSTAIN: begin
          if (bus.gate_off || (sus_cnt_q >= sus_time_s)) begin
            state_d = RELEASE;
          end else begin
            sus_cnt_d = sus_cnt_q + 32'd1;
          end
        end
        RELEASE: begin
          if (acc_q <= rel_s) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q - rel_s;
          end
        end
        BYPASS: begin
          if (bus.gate_off) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = MAX_LEVEL;
          end
        end
        default: begin
          acc_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
